// File: rtl/dcache_pkg.sv
// Shared data cache constants and the data store request payload.
package dcache_pkg;

    localparam int unsigned DCACHE_LINE_WIDTH = 128;
    localparam int unsigned DCACHE_NUM_WORDS  = 256;
    localparam int unsigned DCACHE_BEAT_WIDTH = 64;
    localparam int unsigned NBEATS            = DCACHE_LINE_WIDTH / DCACHE_BEAT_WIDTH;
    localparam int unsigned IDX_W             = $clog2(DCACHE_NUM_WORDS);
    localparam int unsigned BE_W              = DCACHE_LINE_WIDTH / 8;

    // One data store access as seen at the SRAM port.
    typedef struct packed {
        logic                         en;
        logic                         we;
        logic [BE_W-1:0]              be;
        logic [IDX_W-1:0]             addr;
        logic [DCACHE_LINE_WIDTH-1:0] wdata;
    } ds_req_t;

endpackage

// File: rtl/refill_line_assembler.sv
// Collects narrow refill beats into a full line and flags it for a single write.
module refill_line_assembler #(
    parameter int unsigned  LINE_WIDTH = 128,
    parameter int unsigned  BEAT_WIDTH = 64,
    parameter int unsigned  IDX_BITS   = 8,
    localparam int unsigned NB         = LINE_WIDTH / BEAT_WIDTH,
    localparam int unsigned CNT_W      = $clog2(NB)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  beat_valid_i,
    output logic                  beat_ready_o,
    input  logic [IDX_BITS-1:0]   beat_index_i,
    input  logic [BEAT_WIDTH-1:0] beat_data_i,
    input  logic                  line_write_i,
    output logic                  pending_o,
    output logic [IDX_BITS-1:0]   index_o,
    output logic [LINE_WIDTH-1:0] line_o
);

    logic [CNT_W-1:0]                 beat_cnt_q;
    logic [NB-1:0][BEAT_WIDTH-1:0]    line_buf_q;
    logic [IDX_BITS-1:0]              idx_q;
    logic                             pending_q;
    logic                             accept;
    logic                             last_beat;

    assign accept    = beat_valid_i && !pending_q;
    assign last_beat = (beat_cnt_q == CNT_W'(NB - 1));

    // The final beat lands in the buffer on the same edge that raises pending_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_q <= '0;
            line_buf_q <= '0;
            idx_q      <= '0;
            pending_q  <= 1'b0;
        end else begin
            if (accept) begin
                line_buf_q[beat_cnt_q] <= beat_data_i;
                if (last_beat) begin
                    beat_cnt_q <= '0;
                    idx_q      <= beat_index_i;
                    pending_q  <= 1'b1;
                end else begin
                    beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                end
            end else if (line_write_i) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign beat_ready_o = !pending_q;
    assign pending_o    = pending_q;
    assign index_o      = idx_q;
    assign line_o       = line_buf_q;

endmodule

// File: rtl/dcache_data_port_arbiter.sv
// Arbitrates refill line writes, store writes and load reads onto the single data store port.
module dcache_data_port_arbiter
    import dcache_pkg::*;
#(
    parameter int unsigned  LINE_WIDTH = DCACHE_LINE_WIDTH,
    parameter int unsigned  NUM_WORDS  = DCACHE_NUM_WORDS,
    parameter int unsigned  BEAT_WIDTH = DCACHE_BEAT_WIDTH,
    localparam int unsigned IDX_BITS   = $clog2(NUM_WORDS),
    localparam int unsigned LBE_W      = LINE_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  refill_valid_i,
    output logic                  refill_ready_o,
    input  logic [IDX_BITS-1:0]   refill_index_i,
    input  logic [BEAT_WIDTH-1:0] refill_data_i,
    input  logic                  store_req_i,
    output logic                  store_gnt_o,
    input  logic [IDX_BITS-1:0]   store_index_i,
    input  logic [LBE_W-1:0]      store_be_i,
    input  logic [LINE_WIDTH-1:0] store_wdata_i,
    input  logic                  load_req_i,
    output logic                  load_gnt_o,
    input  logic [IDX_BITS-1:0]   load_index_i,
    output logic                  load_rvalid_o,
    output logic [LINE_WIDTH-1:0] load_rdata_o,
    output logic                  ds_en_o,
    output logic                  ds_we_o,
    output logic [LBE_W-1:0]      ds_be_o,
    output logic [IDX_BITS-1:0]   ds_addr_o,
    output logic [LINE_WIDTH-1:0] ds_wdata_o,
    input  logic [LINE_WIDTH-1:0] ds_rdata_i
);

    logic                  pending;
    logic [IDX_BITS-1:0]   refill_idx;
    logic [LINE_WIDTH-1:0] refill_line;
    logic                  store_gnt;
    logic                  load_gnt;
    logic                  rr_q;
    logic                  rvalid_q;
    ds_req_t               ds_req;

    refill_line_assembler #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .IDX_BITS   (IDX_BITS)
    ) i_refill (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .beat_valid_i (refill_valid_i),
        .beat_ready_o (refill_ready_o),
        .beat_index_i (refill_index_i),
        .beat_data_i  (refill_data_i),
        .line_write_i (pending),
        .pending_o    (pending),
        .index_o      (refill_idx),
        .line_o       (refill_line)
    );

    // A completed refill line always wins; otherwise rr_q breaks store/load ties.
    always_comb begin
        store_gnt = 1'b0;
        load_gnt  = 1'b0;
        ds_req    = '0;
        if (pending) begin
            ds_req.en    = 1'b1;
            ds_req.we    = 1'b1;
            ds_req.be    = '1;
            ds_req.addr  = refill_idx;
            ds_req.wdata = refill_line;
        end else if (store_req_i && (!load_req_i || !rr_q)) begin
            store_gnt    = 1'b1;
            ds_req.en    = 1'b1;
            ds_req.we    = 1'b1;
            ds_req.be    = store_be_i;
            ds_req.addr  = store_index_i;
            ds_req.wdata = store_wdata_i;
        end else if (load_req_i) begin
            load_gnt     = 1'b1;
            ds_req.en    = 1'b1;
            ds_req.addr  = load_index_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= load_gnt;
            if (store_gnt) begin
                rr_q <= 1'b1;
            end else if (load_gnt) begin
                rr_q <= 1'b0;
            end
        end
    end

    assign store_gnt_o   = store_gnt;
    assign load_gnt_o    = load_gnt;
    assign load_rvalid_o = rvalid_q;
    assign load_rdata_o  = ds_rdata_i;
    assign ds_en_o       = ds_req.en;
    assign ds_we_o       = ds_req.we;
    assign ds_be_o       = ds_req.be;
    assign ds_addr_o     = ds_req.addr;
    assign ds_wdata_o    = ds_req.wdata;

endmodule

// File: tb/tb_dcache_data_port_arbiter.sv
// Directed bench for the data port arbiter with a behavioural data store and a read scoreboard.
module tb_dcache_data_port_arbiter;

    localparam int unsigned LW  = 128;
    localparam int unsigned BW  = 64;
    localparam int unsigned IW  = 8;
    localparam int unsigned BEW = 16;
    localparam int unsigned NW  = 256;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          refill_valid_i;
    logic          refill_ready_o;
    logic [IW-1:0] refill_index_i;
    logic [BW-1:0] refill_data_i;
    logic          store_req_i;
    logic          store_gnt_o;
    logic [IW-1:0] store_index_i;
    logic [BEW-1:0] store_be_i;
    logic [LW-1:0] store_wdata_i;
    logic          load_req_i;
    logic          load_gnt_o;
    logic [IW-1:0] load_index_i;
    logic          load_rvalid_o;
    logic [LW-1:0] load_rdata_o;
    logic          ds_en_o;
    logic          ds_we_o;
    logic [BEW-1:0] ds_be_o;
    logic [IW-1:0] ds_addr_o;
    logic [LW-1:0] ds_wdata_o;
    logic [LW-1:0] ds_rdata_i = '0;

    logic [LW-1:0] mem     [NW];
    logic [LW-1:0] ref_mem [NW];
    logic [LW-1:0] sb [$];
    int n_checks = 0;
    int n_pass   = 0;

    dcache_data_port_arbiter dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .refill_valid_i (refill_valid_i),
        .refill_ready_o (refill_ready_o),
        .refill_index_i (refill_index_i),
        .refill_data_i  (refill_data_i),
        .store_req_i    (store_req_i),
        .store_gnt_o    (store_gnt_o),
        .store_index_i  (store_index_i),
        .store_be_i     (store_be_i),
        .store_wdata_i  (store_wdata_i),
        .load_req_i     (load_req_i),
        .load_gnt_o     (load_gnt_o),
        .load_index_i   (load_index_i),
        .load_rvalid_o  (load_rvalid_o),
        .load_rdata_o   (load_rdata_o),
        .ds_en_o        (ds_en_o),
        .ds_we_o        (ds_we_o),
        .ds_be_o        (ds_be_o),
        .ds_addr_o      (ds_addr_o),
        .ds_wdata_o     (ds_wdata_o),
        .ds_rdata_i     (ds_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural SRAM: byte-masked write, one-cycle registered read.
    always @(posedge clk_i) begin
        if (ds_en_o) begin
            if (ds_we_o) begin
                for (int b = 0; b < int'(BEW); b++)
                    if (ds_be_o[b]) mem[ds_addr_o][b*8 +: 8] <= ds_wdata_o[b*8 +: 8];
            end else begin
                ds_rdata_i <= mem[ds_addr_o];
            end
        end
    end

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Read return scoreboard.
    always @(negedge clk_i) begin
        if (load_rvalid_o) begin
            if (sb.size() == 0) check("rvalid_spurious", LW'(load_rvalid_o), '0);
            else check("load_rdata", load_rdata_o, sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic ref_store(input logic [IW-1:0] idx, input logic [BEW-1:0] be, input logic [LW-1:0] wd);
        for (int b = 0; b < int'(BEW); b++)
            if (be[b]) ref_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
    endtask

    task automatic do_load(input logic [IW-1:0] idx);
        load_req_i   = 1'b1;
        load_index_i = idx;
        sample();
        check("load_gnt", LW'(load_gnt_o), LW'(1));
        check("load_ds_we", LW'(ds_we_o), '0);
        check("load_ds_addr", LW'(ds_addr_o), LW'(idx));
        sb.push_back(ref_mem[idx]);
        step();
        load_req_i = 1'b0;
    endtask

    task automatic flush();
        sample();
        step();
    endtask

    function automatic logic [BW-1:0] bb_beat(input int l, input int p);
        return {16'hB2B0, 16'(l), 16'hBEA7, 16'(p)};
    endfunction

    initial begin
        logic [BW-1:0] beat_a;
        logic [BW-1:0] beat_b;
        logic [LW-1:0] sw;
        int l;

        for (int i = 0; i < int'(NW); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        rst_ni = 1'b0;
        refill_valid_i = 1'b0; refill_index_i = '0; refill_data_i = '0;
        store_req_i = 1'b0; store_index_i = '0; store_be_i = '0; store_wdata_i = '0;
        load_req_i = 1'b0; load_index_i = '0;

        // Reset state
        step(); step();
        sample();
        check("rst_refill_ready", LW'(refill_ready_o), LW'(1));
        check("rst_rvalid", LW'(load_rvalid_o), '0);
        check("rst_ds_en", LW'(ds_en_o), '0);
        step();
        rst_ni = 1'b1;

        // Refill then read
        refill_valid_i = 1'b1; refill_data_i = 64'h1111_1111_1111_1111; refill_index_i = 8'd9;
        sample();
        check("r1_ready_b0", LW'(refill_ready_o), LW'(1));
        check("r1_idle_ds_en", LW'(ds_en_o), '0);
        step();
        refill_data_i = 64'h2222_2222_2222_2222; refill_index_i = 8'd5;
        sample();
        check("r1_ready_b1", LW'(refill_ready_o), LW'(1));
        step();
        refill_valid_i = 1'b0;
        sample();
        check("r1_ready_wr", LW'(refill_ready_o), '0);
        check("r1_ds_en", LW'(ds_en_o), LW'(1));
        check("r1_ds_we", LW'(ds_we_o), LW'(1));
        check("r1_ds_be", LW'(ds_be_o), LW'(16'hFFFF));
        check("r1_ds_addr", LW'(ds_addr_o), LW'(5));
        check("r1_ds_wdata", ds_wdata_o, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        ref_mem[5] = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        step();
        do_load(8'd5);
        flush();

        // Store merge
        sw = {96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5, 32'hDEAD_BEEF};
        store_req_i = 1'b1; store_index_i = 8'd5; store_be_i = 16'h000F; store_wdata_i = sw;
        sample();
        check("sm_store_gnt", LW'(store_gnt_o), LW'(1));
        check("sm_ds_we", LW'(ds_we_o), LW'(1));
        check("sm_ds_be", LW'(ds_be_o), LW'(16'h000F));
        check("sm_ds_wdata", ds_wdata_o, sw);
        ref_store(8'd5, 16'h000F, sw);
        check("sm_ref_expect", ref_mem[5], {64'h2222_2222_2222_2222, 32'h1111_1111, 32'hDEAD_BEEF});
        step();
        store_req_i = 1'b0;
        do_load(8'd5);
        flush();

        // Contention from reset
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        sw = {4{32'h7777_0007}};
        store_req_i = 1'b1; store_index_i = 8'd7; store_be_i = 16'hFFFF; store_wdata_i = sw;
        load_req_i = 1'b1; load_index_i = 8'd9;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("ct_store_gnt", LW'(store_gnt_o), LW'(i % 2 == 0));
            check("ct_load_gnt", LW'(load_gnt_o), LW'(i % 2 == 1));
            check("ct_rvalid", LW'(load_rvalid_o), LW'(i == 2));
            if (i % 2 == 0) ref_store(8'd7, 16'hFFFF, sw);
            else sb.push_back(ref_mem[9]);
            step();
        end
        store_req_i = 1'b0; load_req_i = 1'b0;
        sample();
        check("ct_rvalid_last", LW'(load_rvalid_o), LW'(1));
        step();

        // Refill priority over a waiting store
        refill_valid_i = 1'b1; refill_data_i = 64'hAAAA_AAAA_AAAA_AAAA; refill_index_i = 8'd0;
        sw = {4{32'h5151_0001}};
        store_req_i = 1'b1; store_index_i = 8'd12; store_be_i = 16'hFFFF; store_wdata_i = sw;
        sample();
        check("rp_store_gnt_c1", LW'(store_gnt_o), LW'(1));
        ref_store(8'd12, 16'hFFFF, sw);
        step();
        refill_data_i = 64'hBBBB_BBBB_BBBB_BBBB; refill_index_i = 8'd11;
        sw = {4{32'h5252_0002}};
        store_wdata_i = sw;
        load_req_i = 1'b1; load_index_i = 8'd5;
        sample();
        check("rp_load_gnt_c2", LW'(load_gnt_o), LW'(1));
        check("rp_store_gnt_c2", LW'(store_gnt_o), '0);
        check("rp_ready_c2", LW'(refill_ready_o), LW'(1));
        sb.push_back(ref_mem[5]);
        step();
        refill_valid_i = 1'b0; load_req_i = 1'b0;
        sample();
        check("rp_store_gnt_wr", LW'(store_gnt_o), '0);
        check("rp_ready_wr", LW'(refill_ready_o), '0);
        check("rp_ds_addr_wr", LW'(ds_addr_o), LW'(11));
        check("rp_ds_wdata_wr", ds_wdata_o, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
        ref_mem[11] = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        step();
        sample();
        check("rp_store_gnt_after", LW'(store_gnt_o), LW'(1));
        check("rp_store_wdata_after", ds_wdata_o, sw);
        ref_store(8'd12, 16'hFFFF, sw);
        step();
        store_req_i = 1'b0;
        do_load(8'd11);
        do_load(8'd12);
        flush();

        // Back-to-back refills, valid held high
        l = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            int ph;
            ph = cyc % 3;
            refill_valid_i = 1'b1;
            refill_data_i  = (ph == 2) ? bb_beat(l + 1, 0) : bb_beat(l, ph);
            refill_index_i = (ph == 1) ? IW'(20 + l) : 8'hFF;
            sample();
            check("bb_ready", LW'(refill_ready_o), LW'(ph != 2));
            if (ph == 2) begin
                check("bb_ds_en", LW'(ds_en_o), LW'(1));
                check("bb_ds_addr", LW'(ds_addr_o), LW'(20 + l));
                check("bb_ds_wdata", ds_wdata_o, {bb_beat(l, 1), bb_beat(l, 0)});
                ref_mem[20 + l] = {bb_beat(l, 1), bb_beat(l, 0)};
                l++;
            end
            step();
        end
        refill_valid_i = 1'b0;
        do_load(8'd23);
        do_load(8'd20);
        flush();

        // Reset after beat 0, with a read in flight
        refill_valid_i = 1'b1; refill_data_i = 64'hEEEE_EEEE_EEEE_EEEE; refill_index_i = 8'd3;
        sample();
        check("ra_ready_b0", LW'(refill_ready_o), LW'(1));
        step();
        refill_valid_i = 1'b0;
        load_req_i = 1'b1; load_index_i = 8'd5;
        sample();
        check("ra_load_gnt", LW'(load_gnt_o), LW'(1));
        rst_ni = 1'b0;
        step();
        load_req_i = 1'b0;
        sample();
        check("ra_rvalid_dropped", LW'(load_rvalid_o), '0);
        check("ra_ready_rst", LW'(refill_ready_o), LW'(1));
        step();
        rst_ni = 1'b1;
        beat_a = 64'h3333_0000_0000_000A;
        beat_b = 64'h3333_0000_0000_000B;
        refill_valid_i = 1'b1; refill_data_i = beat_a; refill_index_i = 8'd3;
        sample();
        check("ra_ready_a", LW'(refill_ready_o), LW'(1));
        step();
        refill_data_i = beat_b;
        sample();
        check("ra_no_abort_write", LW'(ds_en_o), '0);
        check("ra_ready_b", LW'(refill_ready_o), LW'(1));
        step();
        refill_valid_i = 1'b0;
        sample();
        check("ra_ds_en", LW'(ds_en_o), LW'(1));
        check("ra_ds_addr", LW'(ds_addr_o), LW'(3));
        check("ra_ds_wdata", ds_wdata_o, {beat_b, beat_a});
        ref_mem[3] = {beat_b, beat_a};
        step();
        do_load(8'd3);
        flush();

        check("sb_drained", LW'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_data_port_arbiter.md
# dcache_data_port_arbiter

Single-port initiator that drives the data cache data store. It arbitrates three requesters onto the one SRAM port: refill line writes, byte-masked store writes, and line reads for loads. Refill beats arrive narrower than a cache line, so they are assembled in an internal line buffer and written as one full-line write. The block sits between the data cache controller or miss unit and the data store instance.

## Interface
Parameters:
- LINE_WIDTH, ariane_pkg::DCACHE_LINE_WIDTH (128): data store word width.
- NUM_WORDS, wt_cache_pkg::DCACHE_NUM_WORDS: data store depth. Index width IDX_W = $clog2(NUM_WORDS).
- BEAT_WIDTH, 64: refill beat width. LINE_WIDTH must be an integer multiple of it; NBEATS = LINE_WIDTH/BEAT_WIDTH ≥ 2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- refill_valid_i  in  1  refill beat valid.
- refill_ready_o  out  1  refill beat accepted when valid and ready are both high.
- refill_index_i  in  IDX_W  line index, sampled on the final beat only.
- refill_data_i  in  BEAT_WIDTH  beat data, lowest beat first.
- store_req_i  in  1  store write request.
- store_gnt_o  out  1  store granted this cycle.
- store_index_i  in  IDX_W  store line index.
- store_be_i  in  LINE_WIDTH/8  byte enables; all-zero is legal and is a no-op write.
- store_wdata_i  in  LINE_WIDTH  line-aligned store data.
- load_req_i  in  1  line read request.
- load_gnt_o  out  1  load granted this cycle.
- load_index_i  in  IDX_W  load line index.
- load_rvalid_o  out  1  read data valid.
- load_rdata_o  out  LINE_WIDTH  read data.
- ds_en_o  out  1  data store enable.
- ds_we_o  out  1  data store write.
- ds_be_o  out  LINE_WIDTH/8  data store byte enables.
- ds_addr_o  out  IDX_W  data store index.
- ds_wdata_o  out  LINE_WIDTH  data store write data.
- ds_rdata_i  in  LINE_WIDTH  data store read data; valid the cycle after a read enable.

## Operation
- **Registered state:** beat_cnt_q (0..NBEATS-1), line_buf_q, idx_q, pending_q, rr_q, rvalid_q.
- **Refill handshake:** refill_ready_o = !pending_q.
  - On each accepted beat, the beat is written to line_buf_q[beat_cnt_q*BEAT_WIDTH +: BEAT_WIDTH] and beat_cnt_q increments.
  - On the beat where beat_cnt_q = NBEATS-1: beat_cnt_q wraps to 0, idx_q ← refill_index_i, pending_q ← 1.
  - The final beat is written into the line buffer in the same cycle it is accepted, so line_buf_q holds the complete line when pending_q rises.
- **Arbitration priority, highest first:**
  1. pending_q = 1: issue a full-line write with ds_en_o = 1, ds_we_o = 1, ds_be_o all-ones, ds_addr_o = idx_q, ds_wdata_o = line_buf_q. Clear pending_q. No store or load grant this cycle.
  2. Store and load both requesting: grant the side selected by rr_q (0 = store, 1 = load).
  3. Single requester: grant it.
- **Round-robin update:** after any store or load grant, rr_q ← the other side.
- **Store grant:** ds_en_o = 1, ds_we_o = 1, ds_be_o = store_be_i, ds_addr_o = store_index_i, ds_wdata_o = store_wdata_i.
- **Load grant:** ds_en_o = 1, ds_we_o = 0, ds_be_o = 0, ds_addr_o = load_index_i. rvalid_q ← 1.
- **Read return:** load_rvalid_o = rvalid_q. load_rdata_o = ds_rdata_i, passed through combinationally.
- **Idle:** ds_en_o = 0; ds_we_o, ds_be_o and ds_wdata_o are 0.
- **Requester obligations:**
  - Requesters hold req and their payload until granted.
  - A requester may drop req before it is granted.
  - Grants are combinational from req and registered state.
- **Coherence between paths:** the block does not check hazards between a partially assembled refill and a load or store to the same index. The miss unit guarantees none exist.

## Timing
- **Reset values:** beat_cnt_q = 0, pending_q = 0, rr_q = 0, rvalid_q = 0. After reset, refill_ready_o = 1 and load_rvalid_o = 0.
- **Refill:** the line write occurs in the cycle after the final beat is accepted. refill_ready_o is low in that cycle, so a back-to-back refill loses exactly one cycle per line.
- **Load latency:** grant in cycle N, load_rvalid_o and data in cycle N+1.
  - A write granted in cycle N+1 does not disturb load_rdata_o in N+1, because the store updates on the clock edge.
- **Store latency:** the write is visible to a load granted in the following cycle or later.
- **Reset mid-refill:** partial beats are discarded and the counter returns to 0.
- **Reset mid-read:** a pending rvalid is dropped.

## Structure
- A new dcache_pkg entry holds the constants NBEATS and IDX_W.
- The same entry holds a typedef ds_req_t {en, we, be, addr, wdata}, shared with the data store integration.
- Sub-module refill_line_assembler (beat counter, line buffer, pending flag) handles the refill path. The arbiter instantiates it.

## Test plan
- **Refill then read:** two beats 0x1111…, then 0x2222…, at index 5, followed by a load of index 5. Required response: one write with be = 0xFFFF at index 5, then load_rdata_o = {0x2222…, 0x1111…}.
- **Store merge:** store be = 0x000F, wdata low word 0xDEADBEEF, to index 5, then a load of index 5. Required response: low 32 bits read 0xDEADBEEF, upper bits unchanged.
- **Contention:** store and load both requesting for 4 cycles from reset. Required response: grants alternate store, load, store, load; load_rvalid_o high the cycle after each load grant.
- **Refill priority:** final beat accepted while store_req_i is high. Required response: the next cycle issues the refill write with store_gnt_o = 0 and refill_ready_o = 0; the store is granted the cycle after.
- **Back-to-back refills:** 4 lines streamed with refill_valid_i held high. Required response: ready pattern 1,1,0 repeating; 4 line writes at the correct indices.
- **Reset after beat 0:** reset asserted after the first beat is accepted, then a full 2-beat refill at index 3. Required response: index 3 contains only the new beats; no write occurs from the aborted line.
